// File: rtl/seg7_pkg.sv
// Shared 7-segment types and constants (bit6=a .. bit0=g, 1 = lit).
package seg7_pkg;

  typedef logic [6:0] seg7_t;

  localparam seg7_t SEG_ZERO  = 7'h7E;
  localparam seg7_t SEG_BLANK = 7'h00;

  // Decimal digit to segment pattern, shared with the upstream encoder.
  localparam seg7_t SEG_LUT [10] = '{
    7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33,
    7'h5B, 7'h5F, 7'h70, 7'h7F, 7'h7B
  };

  function automatic seg7_t dec_to_seg(input logic [3:0] d);
    dec_to_seg = (d < 4'd10) ? SEG_LUT[d] : SEG_BLANK;
  endfunction

endpackage

// File: rtl/seg7_scan_timer.sv
// Slot/digit scan counters, wrap detection and the frame_start pulse.
module seg7_scan_timer #(
  parameter int DIGITS      = 2,
  parameter int SLOT_CYCLES = 1000,
  localparam int CW = $clog2(SLOT_CYCLES),
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
  input  logic          clk,
  input  logic          rstn,
  output logic [CW-1:0] cnt_nxt,
  output logic [IW-1:0] idx_nxt,
  output logic          slot_wrap,
  output logic          frame_wrap,
  output logic          frame_start
);

  logic [CW-1:0] cnt;
  logic [IW-1:0] idx;

  // Next-state of the counters; downstream registers key off these so the
  // outputs line up with the counter value of the same cycle.
  always_comb begin
    slot_wrap  = (cnt == CW'(SLOT_CYCLES - 1));
    cnt_nxt    = slot_wrap ? '0 : cnt + 1'b1;
    idx_nxt    = idx;
    if (slot_wrap)
      idx_nxt = (idx == IW'(DIGITS - 1)) ? '0 : idx + 1'b1;
    frame_wrap = slot_wrap && (idx == IW'(DIGITS - 1));
  end

  // Counter state; reset lands on (0,0) but that is not a wrap, so no pulse.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt         <= '0;
      idx         <= '0;
      frame_start <= 1'b0;
    end else begin
      cnt         <= cnt_nxt;
      idx         <= idx_nxt;
      frame_start <= frame_wrap;
    end
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 7-segment driver: per-frame shadow buffer, guard time,
// 16-level PWM brightness and leading-zero blanking.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int DIGITS       = 2,
  parameter int SLOT_CYCLES  = 1000,
  parameter int GUARD_CYCLES = 8,
  parameter bit ACTIVE_LOW   = 1'b1
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [DIGITS-1:0][6:0] s_data,
  input  logic [3:0]             brightness,
  input  logic                   blank_lz,
  output logic [6:0]             seg,
  output logic [DIGITS-1:0]      dig_en,
  output logic                   frame_start
);

  localparam int CW   = $clog2(SLOT_CYCLES);
  localparam int IW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int OW   = CW + 4;
  localparam int SPAN = SLOT_CYCLES - GUARD_CYCLES;

  localparam logic [6:0]        SEG_OFF = ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic [DIGITS-1:0] DIG_OFF = ACTIVE_LOW ? '1 : '0;

  logic [CW-1:0] cnt_nxt;
  logic [IW-1:0] idx_nxt;
  logic          slot_wrap, frame_wrap;

  seg7_scan_timer #(
    .DIGITS      (DIGITS),
    .SLOT_CYCLES (SLOT_CYCLES)
  ) u_timer (
    .clk         (clk),
    .rstn        (rstn),
    .cnt_nxt     (cnt_nxt),
    .idx_nxt     (idx_nxt),
    .slot_wrap   (slot_wrap),
    .frame_wrap  (frame_wrap),
    .frame_start (frame_start)
  );

  logic [DIGITS-1:0][6:0] shadow_q, shadow_d;
  logic [3:0]             bri_q, bri_d;
  logic                   loaded_q, loaded_d;
  logic [OW-1:0]          prod, on_len, cnt_x;
  logic [DIGITS-1:0]      blank;
  logic                   run, on_ph, lit;
  seg7_t                  seg_d;
  logic [DIGITS-1:0]      dig_d;

  // Next-state of shadow/brightness plus phase decode for the upcoming cycle.
  always_comb begin
    shadow_d = frame_wrap ? s_data : shadow_q;
    bri_d    = slot_wrap ? brightness : bri_q;
    // Until the first frame has been sampled the shadow holds nothing real,
    // so the whole first frame after reset stays dark.
    loaded_d = loaded_q | frame_wrap;

    prod   = OW'(SPAN) * OW'(bri_d);
    on_len = (bri_d == 4'hF) ? OW'(SPAN) : (prod >> 4);
    cnt_x  = OW'(cnt_nxt);
    on_ph  = (cnt_x >= OW'(GUARD_CYCLES)) && (cnt_x < OW'(GUARD_CYCLES) + on_len);

    // Blank zeros from the top down; a nonzero digit stops the run.
    blank = '0;
    run   = blank_lz;
    for (int j = DIGITS - 1; j >= 1; j--) begin
      run      = run && (shadow_d[j] == SEG_ZERO);
      blank[j] = run;
    end

    lit   = loaded_d && on_ph && !blank[idx_nxt];
    seg_d = lit ? shadow_d[idx_nxt] : SEG_BLANK;
    dig_d = lit ? (DIGITS'(1) << idx_nxt) : '0;
  end

  // Shadow, brightness latch and registered outputs in display polarity.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      shadow_q <= '0;
      bri_q    <= '0;
      loaded_q <= 1'b0;
      seg      <= SEG_OFF;
      dig_en   <= DIG_OFF;
    end else begin
      shadow_q <= shadow_d;
      bri_q    <= bri_d;
      loaded_q <= loaded_d;
      seg      <= ACTIVE_LOW ? ~seg_d : seg_d;
      dig_en   <= ACTIVE_LOW ? ~dig_d : dig_d;
    end
  end

endmodule
